// File: rtl/ray_pkg.sv
// ray_pkg: shared types and defaults for the ray dispatcher slice.
//   DEF_*        default parameter values for the dispatcher
//   vec3_t       three-component vector at the default component width
//   disp_state_e dispatcher FSM state, exposed on the top's stateDbg port
package ray_pkg;

  localparam int DEF_NUM_UNITS      = 4;
  localparam int DEF_POSITION_WIDTH = 16;
  localparam int DEF_ADDRESS_WIDTH  = 32;
  localparam int DEF_DIM_WIDTH      = 11;
  localparam int DEF_PIXEL_BYTES    = 4;

  // Component 0 is x, 1 is y, 2 is z.
  typedef logic [2:0][DEF_POSITION_WIDTH-1:0] vec3_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2
  } disp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a rotating priority pointer.
//   clock, reset  system clock, synchronous active-high reset
//   req_i         request vector
//   advance_i     when high and a grant is issued, the pointer moves to it
//   grant_o       one-hot grant (all zero when no request)
//   any_o         at least one request present
// The search starts one position after the last grant. The pointer resets
// to N-1, so the first grant after reset goes to the lowest requester.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o,
  output logic         any_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic          found;
  int            cand;

  assign any_o = |req_i;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    cand    = 0;
    idx     = '0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N) cand = cand - N;
      idx = PW'(cand);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_d        = idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= PW'(N - 1);
    end else if (advance_i && any_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ray_dispatcher.sv
// ray_dispatcher: walks a frame in raster order, builds each primary ray
// direction incrementally (adders only) plus its framebuffer address, and
// hands rays round-robin to idle ray units.
//   clock, reset          system clock, synchronous active-high reset
//   frameStart            begin a frame (honoured only in IDLE)
//   frameBusy/frameDone   busy level / one-cycle completion pulse
//   frameWidth/Height     frame size, latched on frameStart
//   frameAddress          address of pixel (0,0), latched
//   cameraQ               ray origin, latched, driven on rayQ for the frame
//   corner, dx, dy        direction of (0,0), column step, row step; latched
//   unitStart             one-hot start pulse to the granted unit
//   unitReady, unitBusy   per-unit status from the ray units
//   rayV                  per-unit direction registers
//   pixelAddress          address of the ray being started
//   stateDbg              current FSM state
//
// Handshake: a unit is offered a ray when unitReady is high. The dispatcher
// loads rayV[k] and pixelAddress on the grant edge and raises unitStart[k]
// for exactly one cycle; that cycle is the transfer. A unit pulsed in the
// previous cycle may still show ready, so it is excluded from the next
// arbitration round.
module ray_dispatcher
  import ray_pkg::*;
#(
  parameter int NUM_UNITS      = DEF_NUM_UNITS,
  parameter int POSITION_WIDTH = DEF_POSITION_WIDTH,
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int DIM_WIDTH      = DEF_DIM_WIDTH,
  parameter int PIXEL_BYTES    = DEF_PIXEL_BYTES
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          frameStart,
  output logic                                          frameBusy,
  output logic                                          frameDone,
  input  logic [DIM_WIDTH-1:0]                          frameWidth,
  input  logic [DIM_WIDTH-1:0]                          frameHeight,
  input  logic [ADDRESS_WIDTH-1:0]                      frameAddress,
  input  logic [2:0][POSITION_WIDTH-1:0]                cameraQ,
  input  logic [2:0][POSITION_WIDTH-1:0]                corner,
  input  logic [2:0][POSITION_WIDTH-1:0]                dx,
  input  logic [2:0][POSITION_WIDTH-1:0]                dy,
  output logic [NUM_UNITS-1:0]                          unitStart,
  input  logic [NUM_UNITS-1:0]                          unitReady,
  input  logic [NUM_UNITS-1:0]                          unitBusy,
  output logic [2:0][POSITION_WIDTH-1:0]                rayQ,
  output logic [NUM_UNITS-1:0][2:0][POSITION_WIDTH-1:0] rayV,
  output logic [ADDRESS_WIDTH-1:0]                      pixelAddress,
  output disp_state_e                                   stateDbg
);

  typedef logic [2:0][POSITION_WIDTH-1:0] vec_t;

  // Per-component add; each component wraps independently.
  function automatic vec_t vec_add(input vec_t a, input vec_t b);
    vec_t r;
    for (int c = 0; c < 3; c++) r[c] = a[c] + b[c];
    return r;
  endfunction

  disp_state_e                         state_q;
  logic [DIM_WIDTH-1:0]                width_q, height_q;
  logic [DIM_WIDTH-1:0]                x_q, y_q;
  logic [DIM_WIDTH-1:0]                x_d, y_d;
  vec_t                                dx_q, dy_q;
  vec_t                                cur_v_q, row_v_q;
  vec_t                                cur_v_d, row_v_d;
  logic [ADDRESS_WIDTH-1:0]            cur_addr_q, cur_addr_d;
  vec_t                                ray_q_q;
  logic [NUM_UNITS-1:0][2:0][POSITION_WIDTH-1:0] ray_v_q;
  logic [ADDRESS_WIDTH-1:0]            pix_addr_q;
  logic [NUM_UNITS-1:0]                start_q;
  logic                                done_q;

  logic [NUM_UNITS-1:0] eligible;
  logic [NUM_UNITS-1:0] grant;
  logic                 grant_any;
  logic                 row_end;
  logic                 last_pixel;

  assign eligible = unitReady & ~start_q;

  rr_arbiter #(.N(NUM_UNITS)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req_i     (eligible),
    .advance_i (state_q == ST_DISPATCH),
    .grant_o   (grant),
    .any_o     (grant_any)
  );

  assign row_end    = (x_q == width_q - DIM_WIDTH'(1));
  assign last_pixel = row_end && (y_q == height_q - DIM_WIDTH'(1));

  // Next raster position and accumulators, applied only on a grant.
  // At row end the next row's first direction is the old row start plus dy,
  // so both rowV and curV take the same sum.
  always_comb begin
    x_d        = x_q + DIM_WIDTH'(1);
    y_d        = y_q;
    row_v_d    = row_v_q;
    cur_v_d    = vec_add(cur_v_q, dx_q);
    cur_addr_d = cur_addr_q + ADDRESS_WIDTH'(PIXEL_BYTES);
    if (row_end) begin
      x_d     = '0;
      y_d     = y_q + DIM_WIDTH'(1);
      row_v_d = vec_add(row_v_q, dy_q);
      cur_v_d = vec_add(row_v_q, dy_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      width_q    <= '0;
      height_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      cur_v_q    <= '0;
      row_v_q    <= '0;
      cur_addr_q <= '0;
      ray_q_q    <= '0;
      ray_v_q    <= '0;
      pix_addr_q <= '0;
      start_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      start_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frameStart) begin
            width_q    <= frameWidth;
            height_q   <= frameHeight;
            dx_q       <= dx;
            dy_q       <= dy;
            cur_v_q    <= corner;
            row_v_q    <= corner;
            cur_addr_q <= frameAddress;
            ray_q_q    <= cameraQ;
            x_q        <= '0;
            y_q        <= '0;
            // An empty frame has nothing to dispatch; finish via DRAIN.
            if (frameWidth == '0 || frameHeight == '0) state_q <= ST_DRAIN;
            else                                       state_q <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (grant_any) begin
            start_q    <= grant;
            pix_addr_q <= cur_addr_q;
            for (int k = 0; k < NUM_UNITS; k++) begin
              if (grant[k]) ray_v_q[k] <= cur_v_q;
            end
            x_q        <= x_d;
            y_q        <= y_d;
            row_v_q    <= row_v_d;
            cur_v_q    <= cur_v_d;
            cur_addr_q <= cur_addr_d;
            if (last_pixel) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The final start pulse must have retired before busy is trusted.
          if (start_q == '0 && unitBusy == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign frameBusy    = (state_q != ST_IDLE);
  assign frameDone    = done_q;
  assign unitStart    = start_q;
  assign rayQ         = ray_q_q;
  assign rayV         = ray_v_q;
  assign pixelAddress = pix_addr_q;
  assign stateDbg     = state_q;

endmodule

// File: tb/tb_ray_dispatcher.sv
module tb_ray_dispatcher;
  import ray_pkg::*;

  localparam int NU = 4;
  localparam int PW = 16;
  localparam int AW = 32;
  localparam int DW = 11;

  typedef logic [2:0][PW-1:0] v_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // ---------------- DUT ----------------
  logic                      frameStart = 1'b0;
  logic                      frameBusy, frameDone;
  logic [DW-1:0]             frameWidth = '0, frameHeight = '0;
  logic [AW-1:0]             frameAddress = '0;
  v_t                        cameraQ = '0, corner = '0, dx = '0, dy = '0;
  logic [NU-1:0]             unitStart;
  logic [NU-1:0]             unitReady = '0, unitBusy = '0;
  v_t                        rayQ;
  logic [NU-1:0][2:0][PW-1:0] rayV;
  logic [AW-1:0]             pixelAddress;
  disp_state_e               state_dbg;

  ray_dispatcher #(
    .NUM_UNITS(NU), .POSITION_WIDTH(PW), .ADDRESS_WIDTH(AW),
    .DIM_WIDTH(DW), .PIXEL_BYTES(4)
  ) dut (
    .clock(clock), .reset(reset), .frameStart(frameStart),
    .frameBusy(frameBusy), .frameDone(frameDone),
    .frameWidth(frameWidth), .frameHeight(frameHeight),
    .frameAddress(frameAddress), .cameraQ(cameraQ), .corner(corner),
    .dx(dx), .dy(dy), .unitStart(unitStart), .unitReady(unitReady),
    .unitBusy(unitBusy), .rayQ(rayQ), .rayV(rayV),
    .pixelAddress(pixelAddress), .stateDbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [79:0] exp_q[$];      // {address, direction} in raster order
  logic [79:0] got_q[$];
  int          got_unit_q[$];
  int          got_cyc_q[$];

  logic [NU-1:0] en = '0;     // units taking part
  int            len [NU];    // busy cycles per start
  logic [NU-1:0] busy_m = '0, pend = '0;
  int            cnt [NU];
  v_t            held [NU];
  int            last_fall_cyc = 0;
  int            n_done = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic v_t mk(input logic [PW-1:0] x, input logic [PW-1:0] y, input logic [PW-1:0] z);
    v_t r;
    r[0] = x; r[1] = y; r[2] = z;
    return r;
  endfunction

  function automatic v_t rand_vec();
    v_t r;
    for (int c = 0; c < 3; c++) r[c] = PW'($urandom());
    return r;
  endfunction

  // ---------------- ray unit models + monitor ----------------
  // A unit stays ready in its start cycle, is busy for len cycles after it,
  // then becomes ready again.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      busy_m = '0;
      pend   = '0;
      for (int u = 0; u < NU; u++) held[u] = '0;
    end else begin
      if (frameDone) n_done++;
      check("start_onehot", 80'($onehot0(unitStart)), 80'(1));
      for (int u = 0; u < NU; u++) begin
        if (unitStart[u]) begin
          check("start_to_idle_unit", 80'(en[u] & ~busy_m[u] & ~pend[u]), 80'(1));
          held[u] = rayV[u];
          got_q.push_back({pixelAddress, rayV[u]});
          got_unit_q.push_back(u);
          got_cyc_q.push_back(cyc);
        end else begin
          check("rayV_hold", 80'(rayV[u]), 80'(held[u]));
        end
        if (busy_m[u]) begin
          cnt[u]--;
          if (cnt[u] == 0) begin
            busy_m[u]     = 1'b0;
            last_fall_cyc = cyc;
          end
        end
        if (pend[u]) begin
          pend[u]   = 1'b0;
          busy_m[u] = 1'b1;
          cnt[u]    = len[u];
        end
        if (unitStart[u]) pend[u] = 1'b1;
      end
    end
    unitBusy  = busy_m;
    unitReady = en & ~busy_m;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset      = 1'b1;
    frameStart = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_unit_q.delete();
    got_cyc_q.delete();
  endtask

  // Returns at the first negedge after frameStart was sampled; frame inputs
  // are then scrambled, since the dispatcher must have latched them.
  task automatic start_frame(input int w, input int h, input logic [AW-1:0] base,
                             input v_t cam, input v_t cor, input v_t ddx, input v_t ddy);
    frameWidth   = DW'(w);
    frameHeight  = DW'(h);
    frameAddress = base;
    cameraQ      = cam;
    corner       = cor;
    dx           = ddx;
    dy           = ddy;
    frameStart   = 1'b1;
    @(negedge clock);
    frameStart   = 1'b0;
    frameWidth   = DW'($urandom());
    frameHeight  = DW'($urandom());
    frameAddress = $urandom();
    cameraQ      = rand_vec();
    corner       = rand_vec();
    dx           = rand_vec();
    dy           = rand_vec();
  endtask

  // Reference: V(x,y) = corner + x*dx + y*dy, addr = base + 4*(y*w + x).
  task automatic build_exp(input int w, input int h, input logic [AW-1:0] base,
                           input v_t cor, input v_t ddx, input v_t ddy);
    v_t v;
    exp_q.delete();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        for (int c = 0; c < 3; c++) v[c] = cor[c] + PW'(x) * ddx[c] + PW'(y) * ddy[c];
        exp_q.push_back({base + AW'((y * w + x) * 4), v});
      end
    end
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    logic seen;
    seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (frameDone === 1'b1) begin
        seen = 1'b1;
        dcyc = cyc;
        break;
      end
    end
    check("frame_done_seen", 80'(seen), 80'(1));
  endtask

  task automatic compare_frame();
    int n;
    check("dispatch_count", 80'(got_q.size()), 80'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("dispatch_ray", got_q[i], exp_q[i]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int   dcyc, nd, u0_starts;
    v_t   cam, cor, ddx, ddy;
    logic [79:0] e;
    logic [PW-1:0] vx;
    int   w, h;
    logic [AW-1:0] base;

    for (int u = 0; u < NU; u++) begin
      len[u]  = 2;
      cnt[u]  = 0;
      held[u] = '0;
    end

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_unitStart", 80'(unitStart), 80'(0));
    check("rst_frameBusy", 80'(frameBusy), 80'(0));
    check("rst_frameDone", 80'(frameDone), 80'(0));
    check("rst_rayQ", 80'(rayQ), 80'(0));
    check("rst_rayV", 80'(rayV), 80'(0));
    check("rst_pixelAddress", 80'(pixelAddress), 80'(0));
    check("rst_state", 80'(state_dbg), 80'(ST_IDLE));
    reset = 1'b0;

    // Single unit, 2x2 frame
    en = 4'b0001; len[0] = 3;
    clear_logs();
    cam = mk(16'd1, 16'd2, 16'd3);
    start_frame(2, 2, 32'h1000, cam, mk(0, 0, 100), mk(10, 0, 0), mk(0, 10, 0));
    wait_done(200, dcyc);
    check("s1_count", 80'(got_q.size()), 80'(4));
    if (got_q.size() == 4) begin
      check("s1_ray0", got_q[0], {32'h1000, mk(0, 0, 100)});
      check("s1_ray1", got_q[1], {32'h1004, mk(10, 0, 100)});
      check("s1_ray2", got_q[2], {32'h1008, mk(0, 10, 100)});
      check("s1_ray3", got_q[3], {32'h100C, mk(10, 10, 100)});
      for (int i = 0; i < 4; i++) check("s1_unit", 80'(got_unit_q[i]), 80'(0));
    end
    check("s1_rayQ", 80'(rayQ), 80'(cam));
    @(negedge clock);
    check("s1_done_pulse_width", 80'(frameDone), 80'(0));
    check("s1_busy_after", 80'(frameBusy), 80'(0));

    // Four units, 3x1 frame: consecutive grants 0,1,2
    do_reset();
    en = 4'b1111;
    for (int u = 0; u < NU; u++) len[u] = 2;
    clear_logs();
    cor = rand_vec(); ddx = rand_vec(); ddy = rand_vec();
    build_exp(3, 1, 32'h2000, cor, ddx, ddy);
    start_frame(3, 1, 32'h2000, rand_vec(), cor, ddx, ddy);
    wait_done(200, dcyc);
    compare_frame();
    if (got_q.size() == 3) begin
      for (int i = 0; i < 3; i++) check("s2_unit_order", 80'(got_unit_q[i]), 80'(i));
      check("s2_consecutive_1", 80'(got_cyc_q[1]), 80'(got_cyc_q[0] + 1));
      check("s2_consecutive_2", 80'(got_cyc_q[2]), 80'(got_cyc_q[0] + 2));
    end
    check("s2_done_after_busy_fall", 80'(dcyc), 80'(last_fall_cyc + 1));

    // Unit 0 busy for a long time, others short
    do_reset();
    en = 4'b1111;
    len[0] = 50; len[1] = 2; len[2] = 2; len[3] = 2;
    clear_logs();
    cor = rand_vec(); ddx = rand_vec(); ddy = rand_vec();
    build_exp(4, 2, 32'h3000, cor, ddx, ddy);
    start_frame(4, 2, 32'h3000, rand_vec(), cor, ddx, ddy);
    wait_done(300, dcyc);
    compare_frame();
    u0_starts = 0;
    foreach (got_unit_q[i]) if (got_unit_q[i] == 0) u0_starts++;
    check("s3_unit0_starts", 80'(u0_starts), 80'(1));
    e = exp_q[0];
    check("s3_rayV0_kept", 80'(rayV[0]), 80'(e[47:0]));

    // Zero-width frame
    for (int u = 0; u < NU; u++) len[u] = 2;
    clear_logs();
    start_frame(0, 3, 32'h5000, rand_vec(), rand_vec(), rand_vec(), rand_vec());
    check("s4_busy_cycle", 80'(frameBusy), 80'(1));
    check("s4_no_done_yet", 80'(frameDone), 80'(0));
    check("s4_state_drain", 80'(state_dbg), 80'(ST_DRAIN));
    @(negedge clock);
    check("s4_busy_low", 80'(frameBusy), 80'(0));
    check("s4_done", 80'(frameDone), 80'(1));
    @(negedge clock);
    check("s4_done_cleared", 80'(frameDone), 80'(0));
    check("s4_no_starts", 80'(got_q.size()), 80'(0));

    // Component wrap, frameStart ignored while dispatching
    do_reset();
    en = 4'b0001; len[0] = 5;
    clear_logs();
    cam = mk(16'h1111, 16'h2222, 16'h3333);
    start_frame(2, 1, 32'h4000, cam, mk(16'h7FF0, 0, 0), mk(16'h0020, 0, 0), mk(0, 0, 0));
    @(negedge clock);
    check("s5_in_dispatch", 80'(state_dbg), 80'(ST_DISPATCH));
    frameStart  = 1'b1;
    frameWidth  = 11'd7;
    cameraQ     = mk(16'hAAAA, 16'hBBBB, 16'hCCCC);
    @(negedge clock);
    frameStart  = 1'b0;
    wait_done(200, dcyc);
    check("s5_count", 80'(got_q.size()), 80'(2));
    if (got_q.size() == 2) begin
      e = got_q[0]; vx = e[15:0];
      check("s5_first_x", 80'(vx), 80'(16'h7FF0));
      e = got_q[1]; vx = e[15:0];
      check("s5_wrapped_x", 80'(vx), 80'(16'h8010));
      check("s5_second_addr", 80'(e[79:48]), 80'(32'h4004));
    end
    check("s5_rayQ_kept", 80'(rayQ), 80'(cam));
    repeat (5) @(negedge clock);
    check("s5_no_restart", 80'(frameBusy), 80'(0));

    // Reset in the middle of dispatch
    do_reset();
    en = 4'b1111;
    for (int u = 0; u < NU; u++) len[u] = 3;
    clear_logs();
    start_frame(8, 8, 32'h6000, rand_vec(), rand_vec(), rand_vec(), rand_vec());
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("s6_unitStart", 80'(unitStart), 80'(0));
    check("s6_frameBusy", 80'(frameBusy), 80'(0));
    check("s6_frameDone", 80'(frameDone), 80'(0));
    check("s6_state", 80'(state_dbg), 80'(ST_IDLE));
    check("s6_rayV", 80'(rayV), 80'(0));
    reset = 1'b0;
    clear_logs();
    nd = n_done;
    repeat (10) @(negedge clock);
    check("s6_no_starts", 80'(got_q.size()), 80'(0));
    check("s6_no_done", 80'(n_done), 80'(nd));
    check("s6_idle", 80'(frameBusy), 80'(0));

    // Randomized frames against the reference model
    for (int t = 0; t < 6; t++) begin
      en = 4'($urandom_range(1, 15));
      for (int u = 0; u < NU; u++) len[u] = $urandom_range(1, 6);
      w    = $urandom_range(1, 5);
      h    = $urandom_range(1, 4);
      base = $urandom();
      cam  = rand_vec(); cor = rand_vec(); ddx = rand_vec(); ddy = rand_vec();
      @(negedge clock);
      clear_logs();
      build_exp(w, h, base, cor, ddx, ddy);
      start_frame(w, h, base, cam, cor, ddx, ddy);
      wait_done(2000, dcyc);
      compare_frame();
      check("rnd_rayQ", 80'(rayQ), 80'(cam));
      @(negedge clock);
      check("rnd_done_pulse_width", 80'(frameDone), 80'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
